// File: rtl/fft_pkg.sv
// Shared FFT datapath definitions: frame geometry, bit-reversal helper and
// loader state encoding. Imported by the frame loader and the FFT core.
package fft_pkg;

    localparam int N_POINTS = 16;
    localparam int DATA_W   = 8;
    localparam int ADDR_W   = $clog2(N_POINTS);

    localparam logic [ADDR_W:0] FILL_LAST = (ADDR_W + 1)'(N_POINTS - 1);
    localparam logic [ADDR_W:0] FILL_FULL = (ADDR_W + 1)'(N_POINTS);

    typedef enum logic {
        LD_FILL    = 1'b0,
        LD_PENDING = 1'b1
    } loader_state_t;

    function automatic logic [ADDR_W-1:0] bitrev(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] r;
        r = '0;
        for (int i = 0; i < ADDR_W; i++) begin
            r[i] = a[ADDR_W-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_pin_sync.sv
// Two-flop synchronizer for an asynchronous pin plus a rising-edge pulse.
// The pulse is high for one clk, two clk after the pin is first sampled high.
module fft_pin_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic pin_i,
    output logic pulse_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= pin_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign pulse_o = sync_q & ~prev_q;

endmodule

// File: rtl/fft_frame_loader.sv
// FFT input stage: strobed pin samples are written bit-reversed into a
// ping-pong bank pair; the FFT core reads complete frames in natural order.
//
//   state      | meaning
//   LD_FILL    | write bank accepting samples, fill_count 0..N_POINTS-1
//   LD_PENDING | write bank full, waiting for the core to release the read bank
module fft_frame_loader
    import fft_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_strobe,
    input  logic              in_clear,
    output logic              frame_valid,
    input  logic              frame_done,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W:0]   fill_count,
    output logic              overrun
);

    logic              strobe_pulse;
    loader_state_t     state_q;
    logic [ADDR_W:0]   fill_q;
    logic              rd_sel_q;
    logic              frame_valid_q;
    logic              overrun_q;
    logic [DATA_W-1:0] bank_q [2][N_POINTS];

    logic done_ok;
    logic wr_en;
    logic last_wr;

    fft_pin_sync u_strobe_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .pin_i   (in_strobe),
        .pulse_o (strobe_pulse)
    );

    assign done_ok = frame_done && frame_valid_q;
    assign wr_en   = strobe_pulse && !in_clear && (state_q == LD_FILL);
    assign last_wr = wr_en && (fill_q == FILL_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= LD_FILL;
            fill_q        <= '0;
            rd_sel_q      <= 1'b0;
            frame_valid_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else if (in_clear) begin
            // The discarded write frame is never handed over, so a release
            // arriving together with the clear just empties the read side.
            state_q   <= LD_FILL;
            fill_q    <= '0;
            overrun_q <= 1'b0;
            if (done_ok) begin
                frame_valid_q <= 1'b0;
            end
        end else begin
            case (state_q)
                LD_FILL: begin
                    if (last_wr) begin
                        if (!frame_valid_q || frame_done) begin
                            rd_sel_q      <= ~rd_sel_q;
                            frame_valid_q <= 1'b1;
                            fill_q        <= '0;
                        end else begin
                            state_q <= LD_PENDING;
                            fill_q  <= FILL_FULL;
                        end
                    end else begin
                        if (wr_en) begin
                            fill_q <= fill_q + 1'b1;
                        end
                        if (done_ok) begin
                            frame_valid_q <= 1'b0;
                        end
                    end
                end
                LD_PENDING: begin
                    if (strobe_pulse) begin
                        overrun_q <= 1'b1;
                    end
                    if (done_ok) begin
                        rd_sel_q <= ~rd_sel_q;
                        fill_q   <= '0;
                        state_q  <= LD_FILL;
                    end
                end
                default: state_q <= LD_FILL;
            endcase
        end
    end

    // Bank storage is deliberately not reset; the write lands in the old
    // write bank even on the cycle it becomes the read bank.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            bank_q[~rd_sel_q][bitrev(fill_q[ADDR_W-1:0])] <= in_data;
        end
    end

    assign frame_valid = frame_valid_q;
    assign fill_count  = fill_q;
    assign overrun     = overrun_q;
    assign rd_data     = bank_q[rd_sel_q][rd_addr];

endmodule

// File: tb/tb_fft_frame_loader.sv
// Directed + randomized bench for fft_frame_loader against a queue-based
// frame model (arrival-order samples, natural-order reads).
module tb_fft_frame_loader;

    localparam int N   = 16;
    localparam int LOG = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] in_data;
    logic       in_strobe;
    logic       in_clear;
    logic       frame_valid;
    logic       frame_done;
    logic [3:0] rd_addr;
    logic [7:0] rd_data;
    logic [4:0] fill_count;
    logic       overrun;

    int checks   = 0;
    int failures = 0;

    logic [7:0] wq[$];
    logic [7:0] rframe [N];
    bit         m_fv;
    bit         m_ovr;

    fft_frame_loader dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_data     (in_data),
        .in_strobe   (in_strobe),
        .in_clear    (in_clear),
        .frame_valid (frame_valid),
        .frame_done  (frame_done),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .fill_count  (fill_count),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    function automatic int rev(input int a);
        int r = 0;
        for (int i = 0; i < LOG; i++) r = r * 2 + ((a / (2 ** i)) % 2);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_sample(input logic [7:0] v);
        if (wq.size() == N) begin
            m_ovr = 1'b1;
        end else begin
            wq.push_back(v);
            if (wq.size() == N && !m_fv) begin
                for (int i = 0; i < N; i++) rframe[i] = wq[i];
                wq.delete();
                m_fv = 1'b1;
            end
        end
    endtask

    task automatic model_done();
        if (m_fv) begin
            if (wq.size() == N) begin
                for (int i = 0; i < N; i++) rframe[i] = wq[i];
                wq.delete();
            end else begin
                m_fv = 1'b0;
            end
        end
    endtask

    task automatic model_clear();
        wq.delete();
        m_ovr = 1'b0;
    endtask

    task automatic model_reset();
        wq.delete();
        m_fv  = 1'b0;
        m_ovr = 1'b0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".fv"}, 32'(frame_valid), 32'(m_fv));
        chk({tag, ".fill"}, 32'(fill_count), 32'(wq.size()));
        chk({tag, ".ovr"}, 32'(overrun), 32'(m_ovr));
        if (m_fv) begin
            for (int a = 0; a < N; a++) begin
                rd_addr = 4'(a);
                #1;
                chk($sformatf("%s.rd%0d", tag, a), 32'(rd_data), 32'(rframe[rev(a)]));
            end
        end
    endtask

    // mode 0: plain sample, 1: frame_done in the write cycle, 2: in_clear in the write cycle
    task automatic send_sample(input logic [7:0] v, input int mode);
        bit fv_before;
        @(negedge clk);
        in_data   = v;
        in_strobe = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("pre_write.fv", 32'(frame_valid), 32'(m_fv));
        chk("pre_write.fill", 32'(fill_count), 32'(wq.size()));
        @(negedge clk);
        frame_done = (mode == 1);
        in_clear   = (mode == 2);
        @(posedge clk);
        #1;
        frame_done = 1'b0;
        in_clear   = 1'b0;
        fv_before  = m_fv;
        if (mode == 2) begin
            model_clear();
        end else begin
            model_sample(v);
            if (mode == 1 && fv_before) model_done();
        end
        check_all("samp");
        @(posedge clk);
        @(negedge clk);
        in_strobe = 1'b0;
        in_data   = 8'($urandom);
        repeat (3) @(negedge clk);
    endtask

    task automatic pulse_done();
        @(negedge clk);
        frame_done = 1'b1;
        @(posedge clk);
        #1;
        frame_done = 1'b0;
        model_done();
        check_all("done");
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        in_clear = 1'b1;
        @(posedge clk);
        #1;
        in_clear = 1'b0;
        model_clear();
        check_all("clear");
    endtask

    initial begin
        int r;
        rst_n      = 1'b0;
        in_data    = 8'h00;
        in_strobe  = 1'b0;
        in_clear   = 1'b0;
        frame_done = 1'b0;
        rd_addr    = 4'd0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_all("reset");

        // 1: first frame, bit-reversed placement
        for (int i = 0; i < N; i++) send_sample(8'(i), 0);
        rd_addr = 4'd8;  #1; chk("t1.rd8", 32'(rd_data), 32'd1);
        rd_addr = 4'd12; #1; chk("t1.rd12", 32'(rd_data), 32'd3);
        rd_addr = 4'd15; #1; chk("t1.rd15", 32'(rd_data), 32'd15);
        chk("t1.fill", 32'(fill_count), 32'd0);

        // 2: pending, overrun, release swaps in the pending frame
        pulse_done();
        for (int i = 0; i < 2 * N; i++) send_sample(8'(i), 0);
        chk("t2.fill_full", 32'(fill_count), 32'd16);
        send_sample(8'd99, 0);
        chk("t2.ovr", 32'(overrun), 32'd1);
        pulse_done();
        chk("t2.fv", 32'(frame_valid), 32'd1);
        rd_addr = 4'd8; #1; chk("t2.rd8", 32'(rd_data), 32'd17);
        chk("t2.fill0", 32'(fill_count), 32'd0);
        chk("t2.ovr_sticky", 32'(overrun), 32'd1);
        pulse_clear();
        chk("t2.ovr_clr", 32'(overrun), 32'd0);

        // 3: release coincides with the last write of the next frame
        for (int i = 0; i < N - 1; i++) send_sample(8'($urandom), 0);
        send_sample(8'($urandom), 1);
        chk("t3.fv", 32'(frame_valid), 32'd1);
        chk("t3.ovr", 32'(overrun), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check_all("t3.after");

        // 4: a held strobe gives one sample
        pulse_done();
        @(negedge clk);
        in_data   = 8'hA5;
        in_strobe = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        model_sample(8'hA5);
        chk("t4.fill", 32'(fill_count), 32'd1);
        @(negedge clk);
        in_strobe = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < N - 1; i++) send_sample(8'($urandom), 0);
        rd_addr = 4'd0; #1; chk("t4.rd0", 32'(rd_data), 32'hA5);

        // 5: clear beats a same-cycle edge (even in PENDING), then partial-frame discard
        for (int i = 0; i < N; i++) send_sample(8'($urandom), 0);
        send_sample(8'h77, 2);
        chk("t5.clr_fill", 32'(fill_count), 32'd0);
        chk("t5.clr_ovr", 32'(overrun), 32'd0);
        pulse_done();
        for (int i = 0; i < 7; i++) send_sample(8'($urandom), 0);
        pulse_clear();
        chk("t5.fill0", 32'(fill_count), 32'd0);
        for (int i = 0; i < N; i++) send_sample(8'(8'h40 + i), 0);
        rd_addr = 4'd0; #1; chk("t5.rd0", 32'(rd_data), 32'h40);
        chk("t5.fv", 32'(frame_valid), 32'd1);

        // 6: asynchronous reset mid-frame
        for (int i = 0; i < N; i++) send_sample(8'($urandom), 0);
        send_sample(8'($urandom), 0);
        pulse_done();
        for (int i = 0; i < 9; i++) send_sample(8'($urandom), 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t6.fv", 32'(frame_valid), 32'd0);
        chk("t6.fill", 32'(fill_count), 32'd0);
        chk("t6.ovr", 32'(overrun), 32'd0);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) send_sample(8'($urandom), 0);
        chk("t6.fv_new", 32'(frame_valid), 32'd1);

        // randomized traffic
        for (int it = 0; it < 60; it++) begin
            r = int'($urandom_range(0, 11));
            if (r < 7)       send_sample(8'($urandom), 0);
            else if (r < 9)  send_sample(8'($urandom), 1);
            else if (r < 11) pulse_done();
            else if (($urandom % 2) == 0) send_sample(8'($urandom), 2);
            else             pulse_clear();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
